// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD width and default timing constants for the stopwatch controller.
package stopwatch_pkg;

    localparam int BCD_W = 8;
    localparam int CLR_CYCLES_DEF = 2;
    localparam logic [BCD_W-1:0] MAX_READING_DEF = 8'h99;

    // Button slots in the edge-detector vector
    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_LAP = 2;
    localparam int NUM_BTN = 3;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RUN,
        HOLD,
        STOP
    } sw_state_t;

    function automatic logic is_counting(input sw_state_t s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers one debounced button level and flags its rising edge; the register resets high
// so a button held through reset never produces an edge.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM driving an external BCD seconds counter and 7-segment display.
// Define STOPWATCH_LAP_EN to build the lap-hold feature (HOLD state, lap register, lap_active).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int               CLR_CYCLES  = CLR_CYCLES_DEF,
    parameter logic [BCD_W-1:0] MAX_READING = MAX_READING_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start_stop,
    input  logic             btn_clear,
    input  logic             btn_lap,
    input  logic [BCD_W-1:0] time_reading,
    output logic             counter_init,
    output logic             counter_enable,
    output logic [BCD_W-1:0] display_value,
    output logic             running,
    output logic             lap_active,
    output logic             done
);

    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_vec;
    logic [NUM_BTN-1:0] rise_vec;
    logic               ss_rise;
    logic               clr_rise;
    logic               lap_rise;

    sw_state_t        state_reg;
    sw_state_t        state_next;
    logic [3:0]       clr_cnt_reg;
    logic [3:0]       clr_cnt_next;
    logic             done_next;
    logic [BCD_W-1:0] disp_next;
    logic             at_max;

    logic             counter_init_reg;
    logic             active_reg;
    logic             done_reg;
    logic [BCD_W-1:0] display_reg;

    assign btn_vec = {btn_lap, btn_clear, btn_start_stop};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge u_btn_edge (
                .clk  (clk),
                .rst_n(rst_n),
                .btn  (btn_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    assign ss_rise  = rise_vec[BTN_SS];
    assign clr_rise = rise_vec[BTN_CLR];
    assign lap_rise = rise_vec[BTN_LAP];
    assign at_max   = (time_reading == MAX_READING);

`ifdef STOPWATCH_LAP_EN
    logic [BCD_W-1:0] lap_reg;
    logic [BCD_W-1:0] lap_next;
    logic             lap_active_reg;
`else
    logic unused_lap;
    assign unused_lap = lap_rise;
`endif

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        done_next    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_next     = lap_reg;
`endif
        // Clear beats everything, including a clear already in progress
        if (clr_rise) begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        state_next = IDLE;
                    end else begin
                        clr_cnt_next = clr_cnt_reg + 4'd1;
                    end
                end
                IDLE: begin
                    if (ss_rise) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (at_max) begin
                        state_next = STOP;
                        done_next  = 1'b1;
                    end else if (ss_rise) begin
                        state_next = STOP;
`ifdef STOPWATCH_LAP_EN
                    end else if (lap_rise) begin
                        state_next = HOLD;
                        lap_next   = time_reading;
`endif
                    end
                end
`ifdef STOPWATCH_LAP_EN
                HOLD: begin
                    if (at_max) begin
                        state_next = STOP;
                        done_next  = 1'b1;
                    end else if (ss_rise) begin
                        state_next = STOP;
                    end else if (lap_rise) begin
                        state_next = RUN;
                    end
                end
`endif
                STOP: begin
                    // A stopwatch parked at full scale can only be cleared
                    if (ss_rise && !at_max) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            endcase
        end

`ifdef STOPWATCH_LAP_EN
        disp_next = (state_next == HOLD) ? lap_next : time_reading;
`else
        disp_next = time_reading;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= CLEAR;
            clr_cnt_reg      <= '0;
            counter_init_reg <= 1'b1;
            active_reg       <= 1'b0;
            done_reg         <= 1'b0;
            display_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            clr_cnt_reg      <= clr_cnt_next;
            counter_init_reg <= (state_next == CLEAR);
            active_reg       <= is_counting(state_next);
            done_reg         <= done_next;
            display_reg      <= disp_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg        <= '0;
            lap_active_reg <= 1'b0;
        end else begin
            lap_reg        <= lap_next;
            lap_active_reg <= (state_next == HOLD);
        end
    end

    assign lap_active = lap_active_reg;
`else
    assign lap_active = 1'b0;
`endif

    assign counter_init   = counter_init_reg;
    assign counter_enable = active_reg;
    assign running        = active_reg;
    assign done           = done_reg;
    assign display_value  = display_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized run against a
// behavioural model. Works with or without STOPWATCH_LAP_EN defined.
module tb_stopwatch_ctrl;

    localparam int         CLR     = 2;
    localparam logic [7:0] MAX     = 8'h99;
    localparam int         M_CLEAR = 0;
    localparam int         M_IDLE  = 1;
    localparam int         M_RUN   = 2;
    localparam int         M_HOLD  = 3;
    localparam int         M_STOP  = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic [7:0] tr = 8'h00;
    logic       counter_init;
    logic       counter_enable;
    logic [7:0] display_value;
    logic       running;
    logic       lap_active;
    logic       done;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    int         m_mode;
    int         m_left;
    logic       m_pss, m_pcl, m_plp;
    logic [7:0] m_lap;
    logic [7:0] m_disp;
    logic       m_done;

    stopwatch_ctrl #(
        .CLR_CYCLES (CLR),
        .MAX_READING(MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_stop(btn_ss),
        .btn_clear     (btn_clr),
        .btn_lap       (btn_lap),
        .time_reading  (tr),
        .counter_init  (counter_init),
        .counter_enable(counter_enable),
        .display_value (display_value),
        .running       (running),
        .lap_active    (lap_active),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic ss, input logic cl, input logic lp,
                              input logic [7:0] t);
        logic e_ss, e_cl, e_lp;
        if (!r) begin
            m_mode = M_CLEAR; m_left = CLR;
            m_pss = 1'b1; m_pcl = 1'b1; m_plp = 1'b1;
            m_lap = 8'h00; m_disp = 8'h00; m_done = 1'b0;
            return;
        end
        e_ss = ss & ~m_pss;
        e_cl = cl & ~m_pcl;
        e_lp = lp & ~m_plp;
        m_pss = ss; m_pcl = cl; m_plp = lp;
        m_done = 1'b0;
        if (e_cl) begin
            m_mode = M_CLEAR; m_left = CLR;
        end else if (m_mode == M_CLEAR) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
        end else if ((m_mode == M_RUN || m_mode == M_HOLD) && t == MAX) begin
            m_mode = M_STOP; m_done = 1'b1;
        end else if (e_ss) begin
            if (m_mode == M_IDLE || (m_mode == M_STOP && t != MAX)) m_mode = M_RUN;
            else if (m_mode == M_RUN || m_mode == M_HOLD) m_mode = M_STOP;
        end else if (LAP_ON && e_lp) begin
            if (m_mode == M_RUN) begin
                m_mode = M_HOLD; m_lap = t;
            end else if (m_mode == M_HOLD) begin
                m_mode = M_RUN;
            end
        end
        m_disp = (m_mode == M_HOLD) ? m_lap : t;
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0; btn_ss = 1'b1; tr = 8'h00;
        tick(3);
        checks++; if (counter_init !== 1'b1) $display("FAIL reset_init: got %b want 1", counter_init); else passes++;
        checks++; if (counter_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", counter_enable); else passes++;
        checks++; if ({running, lap_active, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {running, lap_active, done}); else passes++;
        checks++; if (display_value !== 8'h00) $display("FAIL reset_display: got %h want 00", display_value); else passes++;
        rst_n = 1'b1;
        tick(1);
        checks++; if (counter_init !== 1'b1) $display("FAIL clear_cycle2_init: got %b want 1", counter_init); else passes++;
        tick(1);
        checks++; if (counter_init !== 1'b0) $display("FAIL idle_init: got %b want 0", counter_init); else passes++;
        checks++; if (counter_enable !== 1'b0) $display("FAIL idle_enable: got %b want 0", counter_enable); else passes++;
        checks++; if (display_value !== 8'h00) $display("FAIL idle_display: got %h want 00", display_value); else passes++;
        tick(3);
        checks++; if (running !== 1'b0) $display("FAIL held_through_reset: got running=%b want 0", running); else passes++;
        btn_ss = 1'b0;
        tick(1);
    endtask

    task automatic test_start_stop;
        tr = 8'h05; btn_ss = 1'b1;
        tick(1);
        checks++; if ({running, counter_enable} !== 2'b11) $display("FAIL start_run: got %b want 11", {running, counter_enable}); else passes++;
        checks++; if (display_value !== 8'h05) $display("FAIL start_display: got %h want 05", display_value); else passes++;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            checks++; if ({running, counter_init} !== 2'b10) $display("FAIL held_start cycle %0d: got %b want 10", i, {running, counter_init}); else passes++;
        end
        btn_ss = 1'b0; tick(1);
        btn_ss = 1'b1; tick(1);
        checks++; if ({running, counter_enable} !== 2'b00) $display("FAIL stop: got %b want 00", {running, counter_enable}); else passes++;
        btn_ss = 1'b0; tick(1);
        btn_ss = 1'b1; tick(1);
        checks++; if ({counter_enable, counter_init} !== 2'b10) $display("FAIL resume: got %b want 10", {counter_enable, counter_init}); else passes++;
        btn_ss = 1'b0; tick(1);
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap;
        tr = 8'h13; tick(1);
        btn_lap = 1'b1; tick(1);
        checks++; if ({lap_active, display_value} !== {1'b1, 8'h13}) $display("FAIL lap_enter: got %b/%h want 1/13", lap_active, display_value); else passes++;
        btn_lap = 1'b0; tr = 8'h14; tick(1);
        checks++; if (display_value !== 8'h13) $display("FAIL lap_hold14: got %h want 13", display_value); else passes++;
        tr = 8'h15; tick(1);
        checks++; if ({counter_enable, display_value} !== {1'b1, 8'h13}) $display("FAIL lap_hold15: got %b/%h want 1/13", counter_enable, display_value); else passes++;
        btn_lap = 1'b1; tick(1);
        checks++; if ({lap_active, display_value} !== {1'b0, 8'h15}) $display("FAIL lap_release: got %b/%h want 0/15", lap_active, display_value); else passes++;
        btn_lap = 1'b0; tr = 8'h16; tick(1);
        checks++; if ({running, display_value} !== {1'b1, 8'h16}) $display("FAIL lap_tracking: got %b/%h want 1/16", running, display_value); else passes++;
    endtask
`else
    task automatic test_no_lap;
        for (int i = 0; i < 3; i++) begin
            tr = 8'h30 + 8'(i);
            btn_lap = 1'b1; tick(1);
            checks++; if ({running, lap_active, display_value} !== {2'b10, tr}) $display("FAIL no_lap %0d: got %b%b/%h want 10/%h", i, running, lap_active, display_value, tr); else passes++;
            btn_lap = 1'b0; tick(1);
        end
    endtask
`endif

    task automatic test_clear_priority;
        btn_clr = 1'b1; btn_ss = 1'b1; tick(1);
        checks++; if ({counter_init, counter_enable, running} !== 3'b100) $display("FAIL clear_wins: got %b want 100", {counter_init, counter_enable, running}); else passes++;
        btn_clr = 1'b0; btn_ss = 1'b0; tick(2);
        checks++; if ({counter_init, running} !== 2'b00) $display("FAIL clear_to_idle: got %b want 00", {counter_init, running}); else passes++;
        tick(3);
        checks++; if (running !== 1'b0) $display("FAIL no_run_after_clear: got %b want 0", running); else passes++;
    endtask

    task automatic test_auto_stop;
        tr = 8'h97; btn_ss = 1'b1; tick(1);
        btn_ss = 1'b0; tr = 8'h98; tick(1);
        checks++; if (running !== 1'b1) $display("FAIL auto_pre_run: got %b want 1", running); else passes++;
        tr = 8'h99; tick(1);
        checks++; if ({running, counter_enable, done} !== 3'b001) $display("FAIL auto_stop: got %b want 001", {running, counter_enable, done}); else passes++;
        checks++; if (display_value !== 8'h99) $display("FAIL auto_display: got %h want 99", display_value); else passes++;
        tick(1);
        checks++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else passes++;
        btn_ss = 1'b1; tick(1);
        checks++; if ({running, counter_enable} !== 2'b00) $display("FAIL max_ignores_start: got %b want 00", {running, counter_enable}); else passes++;
        btn_ss = 1'b0; tick(1);
        btn_clr = 1'b1; tick(1);
        checks++; if (counter_init !== 1'b1) $display("FAIL max_clear: got %b want 1", counter_init); else passes++;
        btn_clr = 1'b0; tick(2);
    endtask

    task automatic test_reset_mid_run;
        tr = 8'h20; btn_ss = 1'b1; tick(1);
        btn_ss = 1'b0; tick(1);
        if (LAP_ON) begin
            btn_lap = 1'b1; tick(1);
            btn_lap = 1'b0; tr = 8'h21; tick(1);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({counter_enable, running, lap_active, counter_init} !== 4'b0001) $display("FAIL mid_reset_flags: got %b want 0001", {counter_enable, running, lap_active, counter_init}); else passes++;
        checks++; if (display_value !== 8'h00) $display("FAIL mid_reset_display: got %h want 00", display_value); else passes++;
        tick(2);
        rst_n = 1'b1; tick(2);
        checks++; if ({running, counter_init, display_value} !== {2'b00, tr}) $display("FAIL mid_reset_recover: got %b%b/%h want 00/%h", running, counter_init, display_value, tr); else passes++;
    endtask

    task automatic test_random;
        logic [12:0] exp_v, got_v;
        int          r;
        for (int i = 0; i < 3000; i++) begin
            rst_n = (i < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 15) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 5) == 0) btn_lap = ~btn_lap;
            r = $urandom_range(0, 15);
            if (r == 0) tr = 8'h99;
            else if (r < 4) tr = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            @(posedge clk);
            model_step(rst_n, btn_ss, btn_clr, btn_lap, tr);
            #1;
            exp_v = {m_mode == M_CLEAR, m_mode == M_RUN || m_mode == M_HOLD, m_disp,
                     m_mode == M_RUN || m_mode == M_HOLD, m_mode == M_HOLD, m_done};
            got_v = {counter_init, counter_enable, display_value, running, lap_active, done};
            checks++;
            if (got_v !== exp_v) $display("FAIL random cycle %0d: got init/en/disp/run/lap/done=%b want %b", i, got_v, exp_v);
            else passes++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start_stop();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`else
        test_no_lap();
`endif
        test_clear_priority();
        test_auto_stop();
        test_reset_mid_run();
        test_random();
        tick(1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 2, number of clk cycles counter_init is held high per clear (range 1..15).
REQ-002 SHALL have parameter MAX_READING, default 8'h99, BCD reading at which a running stopwatch auto-stops.
REQ-003 SHALL have port clk  input  1  single system clock (100 MHz); all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_start_stop  input  1  debounced level, start/stop request.
REQ-006 SHALL have port btn_clear  input  1  debounced level, clear request.
REQ-007 SHALL have port btn_lap  input  1  debounced level, lap hold/release request.
REQ-008 SHALL have port time_reading  input  8  BCD reading from Counter, [7:4] tens of seconds, [3:0] ones of seconds.
REQ-009 SHALL have port counter_init  output  1  drives Counter init_regs.
REQ-010 SHALL have port counter_enable  output  1  drives Counter count_enabled.
REQ-011 SHALL have port display_value  output  8  BCD value for the 7-segment display.
REQ-012 SHALL have ports running (output, 1, state RUN or HOLD), lap_active (output, 1, state HOLD) and done (output, 1, one-cycle pulse on auto-stop).

Function
REQ-013 SHALL register each button once (btn_q) and act only on rising edge btn & ~btn_q; a held level SHALL produce exactly one action.
REQ-014 SHALL implement states CLEAR, IDLE, RUN, HOLD, STOP; all outputs registered, changing on the same clk edge as the state change (1-cycle latency from the button's first sampled-high edge).
REQ-015 CLEAR: counter_init=1, counter_enable=0; SHALL stay exactly CLR_CYCLES cycles, then go to IDLE; button edges during CLEAR SHALL be discarded.
REQ-016 IDLE: start_stop edge -> RUN; lap edge ignored.
REQ-017 RUN: counter_enable=1; start_stop edge -> STOP; lap edge -> HOLD, capturing time_reading into the lap register on that edge.
REQ-018 HOLD: counter_enable=1, display_value = lap register; lap edge -> RUN; start_stop edge -> STOP.
REQ-019 STOP: counter_enable=0; start_stop edge -> RUN (resume, no clear); lap edge ignored.
REQ-020 In CLEAR, IDLE, RUN, STOP display_value SHALL equal time_reading registered one cycle.
REQ-021 Clear edge SHALL move any state (including CLEAR, restarting the count) to CLEAR; priority on simultaneous edges: clear > start_stop > lap.
REQ-022 In RUN or HOLD, time_reading == MAX_READING SHALL force STOP and pulse done for one cycle, overriding a coincident start_stop or lap edge (clear still wins).
REQ-023 STOP with time_reading == MAX_READING SHALL ignore start_stop; only clear leaves it.

Reset
REQ-024 rst_n low SHALL immediately force: state CLEAR, clear counter 0, counter_init=1, counter_enable=0, display_value=8'h00, lap register=8'h00, running=0, lap_active=0, done=0, all btn_q=1.
REQ-025 After rst_n release the block SHALL complete a full CLEAR (CLR_CYCLES cycles) before IDLE; buttons held through reset SHALL not trigger actions.
REQ-026 rst_n asserted mid-RUN or mid-HOLD SHALL discard the lap value and stop counting within the same cycle.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN: when defined, HOLD state, lap register and lap_active are implemented per REQ-017/018.
REQ-028 Without STOPWATCH_LAP_EN, btn_lap SHALL be ignored, HOLD unreachable, lap_active tied 0, display_value always per REQ-020.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state encoding (CLEAR, IDLE, RUN, HOLD, STOP), BCD width 8, and default CLR_CYCLES/MAX_READING constants.
REQ-030 Sub-module btn_edge (register + rising-edge detect, reset value 1) SHALL be instantiated once per button.

Verification
REQ-031 Reset 3 cycles, release -> counter_init high exactly 2 cycles, then IDLE with counter_enable=0, display_value=8'h00.
REQ-032 start_stop held 10 cycles in IDLE -> RUN once, counter_enable=1 next cycle; second edge -> STOP; third -> RUN without counter_init.
REQ-033 (LAP_EN) RUN, time_reading=8'h13, lap edge -> display_value holds 8'h13 while time_reading advances to 8'h15; lap edge -> display_value tracks 8'h15 next cycle.
REQ-034 clear and start_stop edges same cycle in RUN -> CLEAR, counter_init=1, counter_enable=0, no RUN afterwards.
REQ-035 RUN, time_reading driven to 8'h99 -> STOP, done one-cycle pulse, later start_stop edge ignored, clear edge -> CLEAR.
REQ-036 Without LAP_EN, lap edges in RUN -> no state change, lap_active=0, display_value tracks time_reading.
